// File: rtl/mac_buf_pkg.sv
// rtl/mac_buf_pkg.sv - shared types and constants for the MAC RX packet buffer
package mac_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  localparam int DESC_ADDR_W = 11;
  localparam int DESC_LEN_W  = 16;

  // Descriptor layout at the default buffer geometry: start word address, byte length
  typedef struct packed {
    logic [DESC_ADDR_W-1:0] start_addr;
    logic [DESC_LEN_W-1:0]  byte_len;
  } desc_t;

  localparam logic [1:0] BEN_FULL   = 2'd0;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/mac_buf_space_calc.sv
// rtl/mac_buf_space_calc.sv - circular buffer free-space compare
module mac_buf_space_calc #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 380
) (
  input  logic [ADDR_W:0] wr_ptr,
  input  logic [ADDR_W:0] rd_ptr,
  output logic            space_ok
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] NEED  = MAX_WORDS[ADDR_W:0];

  logic [ADDR_W:0] used;
  logic [ADDR_W:0] free;

  assign used     = wr_ptr - rd_ptr;
  assign free     = DEPTH - used;
  assign space_ok = (free >= NEED);

endmodule

// File: rtl/mac_rx_pkt_capture.sv
// rtl/mac_rx_pkt_capture.sv - MAC RX FIFO to circular word buffer with descriptors
module mac_rx_pkt_capture
  import mac_buf_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 380,
  parameter int LEN_W     = 16
) (
  input  logic                    mac_clk_i,
  input  logic                    mac_rst_i,
  input  logic [31:0]             mac_rxd_i,
  input  logic [1:0]              mac_ben_i,
  input  logic                    mac_rxda_i,
  input  logic                    mac_rxsop_i,
  input  logic                    mac_rxeop_i,
  input  logic                    mac_rxdv_i,
  output logic                    mac_rxrqrd_o,
  output logic                    buf_wr_en_o,
  output logic [ADDR_W-1:0]       buf_wr_addr_o,
  output logic [31:0]             buf_wr_data_o,
  input  logic [ADDR_W:0]         buf_rd_ptr_i,
  output logic [ADDR_W:0]         buf_wr_ptr_o,
  input  logic                    desc_full_i,
  output logic                    desc_wr_en_o,
  output logic [ADDR_W+LEN_W-1:0] desc_data_o,
  output logic [15:0]             pkt_cnt_o,
  output logic [15:0]             drop_cnt_o
);

  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] MAX_CNT = MAX_WORDS[LEN_W-1:0];

  rx_state_t state, state_n;

  logic [ADDR_W:0]  wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]  start_ptr, start_n;
  logic [ADDR_W:0]  commit_n;
  logic [ADDR_W:0]  base_ptr;
  logic [LEN_W-1:0] word_cnt, cnt_n;
  logic             space_ok;
  logic             sop_ok;

  logic                    wr_en_n;
  logic [ADDR_W-1:0]       wr_addr_n;
  logic                    desc_en_n;
  logic [ADDR_W+LEN_W-1:0] desc_n;
  logic                    pkt_inc;
  logic [1:0]              drop_add;

  // Bytes in a packet of 'words' words whose last word has 'ben' empty bytes
  function automatic logic [LEN_W-1:0] byte_len(input logic [LEN_W-1:0] words,
                                                input logic [1:0]       ben);
    return {words[LEN_W-3:0], 2'b00} - {{(LEN_W-2){1'b0}}, ben};
  endfunction

  // A SOP arriving mid-packet reuses the abandoned packet's start as its base
  assign base_ptr = (state == RECV) ? start_ptr : wr_ptr;
  assign sop_ok   = space_ok & ~desc_full_i;

  mac_buf_space_calc #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) u_space (
    .wr_ptr   (base_ptr),
    .rd_ptr   (buf_rd_ptr_i),
    .space_ok (space_ok)
  );

  // Next-state, buffer write, commit and drop decisions for the current beat
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    start_n   = start_ptr;
    cnt_n     = word_cnt;
    commit_n  = buf_wr_ptr_o;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_ptr[ADDR_W-1:0];
    desc_en_n = 1'b0;
    desc_n    = '0;
    pkt_inc   = 1'b0;
    drop_add  = 2'd0;
    if (mac_rxdv_i) begin
      if (mac_rxsop_i) begin
        wr_ptr_n = base_ptr;
        if (sop_ok) begin
          drop_add  = (state == RECV) ? 2'd1 : 2'd0;
          wr_en_n   = 1'b1;
          wr_addr_n = base_ptr[ADDR_W-1:0];
          start_n   = base_ptr;
          cnt_n     = CNT_ONE;
          wr_ptr_n  = base_ptr + PTR_ONE;
          if (mac_rxeop_i) begin
            desc_en_n = 1'b1;
            desc_n    = {base_ptr[ADDR_W-1:0], byte_len(CNT_ONE, mac_ben_i)};
            commit_n  = base_ptr + PTR_ONE;
            pkt_inc   = 1'b1;
            state_n   = IDLE;
          end else begin
            state_n = RECV;
          end
        end else begin
          drop_add = (state == RECV) ? 2'd2 : 2'd1;
          state_n  = mac_rxeop_i ? IDLE : DROP;
        end
      end else begin
        case (state)
          RECV: begin
            wr_en_n  = 1'b1;
            wr_ptr_n = wr_ptr + PTR_ONE;
            cnt_n    = word_cnt + CNT_ONE;
            if (mac_rxeop_i) begin
              desc_en_n = 1'b1;
              desc_n    = {start_ptr[ADDR_W-1:0], byte_len(word_cnt + CNT_ONE, mac_ben_i)};
              commit_n  = wr_ptr + PTR_ONE;
              pkt_inc   = 1'b1;
              state_n   = IDLE;
            end else if (word_cnt + CNT_ONE == MAX_CNT) begin
              wr_ptr_n = start_ptr;
              drop_add = 2'd1;
              state_n  = DROP;
            end
          end
          DROP: begin
            if (mac_rxeop_i) state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Packet state and uncommitted write pointer
  always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
    if (mac_rst_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      start_ptr <= start_n;
      word_cnt  <= cnt_n;
    end
  end

  // Registered buffer, descriptor, pointer and statistics outputs
  always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
    if (mac_rst_i) begin
      mac_rxrqrd_o  <= 1'b0;
      buf_wr_en_o   <= 1'b0;
      buf_wr_addr_o <= '0;
      buf_wr_data_o <= '0;
      buf_wr_ptr_o  <= '0;
      desc_wr_en_o  <= 1'b0;
      desc_data_o   <= '0;
      pkt_cnt_o     <= '0;
      drop_cnt_o    <= '0;
    end else begin
      mac_rxrqrd_o  <= mac_rxda_i;
      buf_wr_en_o   <= wr_en_n;
      buf_wr_addr_o <= wr_addr_n;
      buf_wr_data_o <= mac_rxd_i;
      buf_wr_ptr_o  <= commit_n;
      desc_wr_en_o  <= desc_en_n;
      desc_data_o   <= desc_n;
      pkt_cnt_o     <= pkt_cnt_o + {15'd0, pkt_inc};
      drop_cnt_o    <= drop_cnt_o + {14'd0, drop_add};
    end
  end

endmodule

// File: tb/tb_mac_rx_pkt_capture.sv
// tb/tb_mac_rx_pkt_capture.sv - self-checking bench for mac_rx_pkt_capture
module tb_mac_rx_pkt_capture;
  import mac_buf_pkg::*;

  localparam int ADDR_W    = 11;
  localparam int LEN_W     = 16;
  localparam int MAX_WORDS = 380;
  localparam int DEPTH     = 2048;
  localparam int PTR_MOD   = 4096;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [31:0]             rxd = '0;
  logic [1:0]              ben = '0;
  logic                    rxda = 1'b0, sop = 1'b0, eop = 1'b0, dv = 1'b0;
  logic                    rqrd;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [31:0]             wr_data;
  logic [ADDR_W:0]         rd_ptr = '0;
  logic [ADDR_W:0]         wr_ptr_out;
  logic                    desc_full = 1'b0;
  logic                    desc_en;
  logic [ADDR_W+LEN_W-1:0] desc_data;
  logic [15:0]             pkt_cnt, drop_cnt;

  mac_rx_pkt_capture #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W)) dut (
    .mac_clk_i     (clk),
    .mac_rst_i     (rst),
    .mac_rxd_i     (rxd),
    .mac_ben_i     (ben),
    .mac_rxda_i    (rxda),
    .mac_rxsop_i   (sop),
    .mac_rxeop_i   (eop),
    .mac_rxdv_i    (dv),
    .mac_rxrqrd_o  (rqrd),
    .buf_wr_en_o   (wr_en),
    .buf_wr_addr_o (wr_addr),
    .buf_wr_data_o (wr_data),
    .buf_rd_ptr_i  (rd_ptr),
    .buf_wr_ptr_o  (wr_ptr_out),
    .desc_full_i   (desc_full),
    .desc_wr_en_o  (desc_en),
    .desc_data_o   (desc_data),
    .pkt_cnt_o     (pkt_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Packet-level model: where each accepted word lands, what gets committed or dropped
  int m_wr, m_start, m_commit, m_words, m_pkts, m_drops, m_used;
  bit m_in_pkt;
  bit e_wr_en, e_desc_en, e_rqrd;
  int e_addr, e_desc;
  logic [31:0] e_data;

  task take_word();
    e_wr_en = 1'b1;
    e_addr  = m_wr % DEPTH;
    e_data  = rxd;
    m_wr    = (m_wr + 1) % PTR_MOD;
    m_words++;
    if (eop) begin
      e_desc_en = 1'b1;
      e_desc    = ((m_start % DEPTH) << LEN_W) | (m_words * 4 - int'(ben));
      m_commit  = m_wr;
      m_pkts++;
      m_in_pkt  = 1'b0;
    end else if (m_words >= MAX_WORDS) begin
      m_drops++;
      m_wr     = m_start;
      m_in_pkt = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr = 0; m_start = 0; m_commit = 0; m_words = 0;
      m_pkts = 0; m_drops = 0; m_in_pkt = 1'b0;
      e_wr_en = 1'b0; e_desc_en = 1'b0; e_rqrd = 1'b0;
      e_addr = 0; e_desc = 0; e_data = '0;
    end else begin
      e_wr_en   = 1'b0;
      e_desc_en = 1'b0;
      e_rqrd    = rxda;
      if (dv) begin
        if (sop) begin
          if (m_in_pkt) begin
            m_drops++;
            m_wr     = m_start;
            m_in_pkt = 1'b0;
          end
          m_used = (m_wr - int'(rd_ptr) + PTR_MOD) % PTR_MOD;
          if ((DEPTH - m_used) >= MAX_WORDS && !desc_full) begin
            m_start  = m_wr;
            m_words  = 0;
            m_in_pkt = 1'b1;
            take_word();
          end else begin
            m_drops++;
          end
        end else if (m_in_pkt) begin
          take_word();
        end
      end
    end
  end

  desc_t       last_desc;
  int unsigned wr_log[$];

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back(int'(wr_addr));
    if (desc_en) last_desc = desc_t'(desc_data);
    if (chk_en) begin
      check("rqrd", rqrd, e_rqrd);
      check("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
      end
      check("desc_en", desc_en, e_desc_en);
      if (e_desc_en) check("desc_data", desc_data, e_desc);
      check("wr_ptr", wr_ptr_out, m_commit);
      check("pkt_cnt", pkt_cnt, m_pkts % 65536);
      check("drop_cnt", drop_cnt, m_drops % 65536);
    end
  end

  task automatic beat(input bit v, input bit s, input bit e, input logic [1:0] b,
                      input logic [31:0] d);
    @(negedge clk);
    #1;
    dv = v; sop = s; eop = e; ben = b; rxd = d; rxda = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic send_part(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(1'b1, i == 0, 1'b0, 2'd0, base + i);
  endtask

  task automatic send_pkt(input int n, input logic [1:0] b, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(1'b1, i == 0, i == n - 1, b, base + i);
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; dv = 0; sop = 0; eop = 0; rxda = 0; rd_ptr = '0; desc_full = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_desc_en", desc_en, 0);
    check("rst_wr_ptr", wr_ptr_out, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_rqrd", rqrd, 0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    idle(2);

    send_pkt(16, 2'd0, 32'h1000_0000);
    check("t1_start", last_desc.start_addr, 0);
    check("t1_len", last_desc.byte_len, 64);
    check("t1_wr_ptr", wr_ptr_out, 16);
    check("t1_pkt_cnt", pkt_cnt, 1);

    send_pkt(16, 2'd3, 32'h2000_0000);
    check("t2_start", last_desc.start_addr, 16);
    check("t2_len", last_desc.byte_len, 61);
    check("t2_wr_ptr", wr_ptr_out, 32);

    send_pkt(MAX_WORDS + 1, 2'd0, 32'h3000_0000);
    check("t3_drop_cnt", drop_cnt, 1);
    check("t3_wr_ptr", wr_ptr_out, 32);
    send_pkt(16, 2'd0, 32'h3100_0000);
    check("t3_start", last_desc.start_addr, 32);

    send_part(5, 32'h4000_0000);
    send_pkt(16, 2'd0, 32'h4100_0000);
    check("t4_drop_cnt", drop_cnt, 2);
    check("t4_start", last_desc.start_addr, 48);
    check("t4_pkt_cnt", pkt_cnt, 4);

    rd_ptr = 12'd2412;
    send_pkt(16, 2'd0, 32'h5000_0000);
    check("t5_low_space_drop", drop_cnt, 3);
    rd_ptr = 12'd64;
    send_pkt(16, 2'd0, 32'h5100_0000);
    check("t5_start", last_desc.start_addr, 64);
    desc_full = 1'b1;
    send_pkt(16, 2'd0, 32'h5200_0000);
    desc_full = 1'b0;
    check("t5_full_drop", drop_cnt, 4);
    send_pkt(1, 2'd2, 32'h5300_0000);
    check("t5_single_start", last_desc.start_addr, 80);
    check("t5_single_len", last_desc.byte_len, 2);
    check("t5_single_wr_ptr", wr_ptr_out, 81);
    beat(1'b1, 1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF);
    idle(2);
    check("stray_drop_cnt", drop_cnt, 4);

    send_part(5, 32'h6000_0000);
    do_reset();
    idle(2);

    for (int k = 0; k < 5; k++) begin
      rd_ptr = 12'(k * MAX_WORDS);
      send_pkt(MAX_WORDS, BEN_FULL, 32'h7000_0000 + k * 32'h1_0000);
    end
    rd_ptr = 12'd1900;
    send_pkt(140, BEN_FULL, 32'h7800_0000);
    check("fill_wr_ptr", wr_ptr_out, 2040);
    rd_ptr = 12'd2040;
    wr_log.delete();
    send_pkt(16, BEN_FULL, 32'h8000_0000);
    check("wrap_writes", wr_log.size(), 16);
    if (wr_log.size() == 16) begin
      check("wrap_addr0", wr_log[0], 2040);
      check("wrap_addr7", wr_log[7], 2047);
      check("wrap_addr8", wr_log[8], 0);
      check("wrap_addr15", wr_log[15], 7);
    end
    check("wrap_start", last_desc.start_addr, 2040);
    check("wrap_len", last_desc.byte_len, 64);
    check("wrap_wr_ptr", wr_ptr_out, 2056);
    check("wrap_pkt_cnt", pkt_cnt, 7);

    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
